// File: rtl/deque_sequencer.sv
// rtl/deque_sequencer.sv - command front-end expanding PUSH/POP/PEEK/REPLACE/MOVE into dual-deque strobes
module deque_sequencer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic              cmd_deque,
    input  logic              cmd_end,
    input  logic              cmd_dst_deque,
    input  logic              cmd_dst_end,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [7:0]        err_count,
    output logic              dq_sel,
    output logic              dq_end,
    output logic              dq_push,
    output logic              dq_pop,
    output logic [DATA_W-1:0] dq_wdata,
    input  logic [DATA_W-1:0] dq_rdata,
    input  logic              empty0,
    input  logic              full0,
    input  logic              empty1,
    input  logic              full1
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_EXEC,
        S_MPUSH,
        S_RESP
    } state_t;

    localparam logic [2:0] OP_NOP     = 3'b000;
    localparam logic [2:0] OP_PUSH    = 3'b001;
    localparam logic [2:0] OP_POP     = 3'b010;
    localparam logic [2:0] OP_PEEK    = 3'b011;
    localparam logic [2:0] OP_REPLACE = 3'b100;
    localparam logic [2:0] OP_MOVE    = 3'b101;

    state_t            state, next_state;
    logic [2:0]        op_q;
    logic              deque_q, end_q, dst_deque_q, dst_end_q;
    logic [DATA_W-1:0] data_q;
    logic              sel_q, dqend_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_err_q;
    logic [7:0]        err_count_q;

    logic              src_empty, src_full, dst_full;
    logic              exec_err;
    logic              push_c, pop_c;
    logic [DATA_W-1:0] wdata_c;
    logic              cmd_illegal, cmd_direct;

    assign cmd_illegal = (cmd_op[2:1] == 2'b11);
    assign cmd_direct  = cmd_illegal || (cmd_op == OP_NOP);

    assign src_empty = deque_q ? empty1 : empty0;
    assign src_full  = deque_q ? full1 : full0;
    assign dst_full  = dst_deque_q ? full1 : full0;

    always_comb begin
        exec_err = 1'b0;
        case (op_q)
            OP_PUSH:                    exec_err = src_full;
            OP_POP, OP_PEEK, OP_REPLACE: exec_err = src_empty;
            OP_MOVE:                    exec_err = src_empty || (dst_full && (dst_deque_q != deque_q));
            default:                    exec_err = 1'b0;
        endcase
    end

    always_comb begin
        next_state = state;
        push_c     = 1'b0;
        pop_c      = 1'b0;
        wdata_c    = '0;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    next_state = cmd_direct ? S_RESP : S_SEL;
                end
            end
            S_SEL: begin
                next_state = S_EXEC;
            end
            S_EXEC: begin
                next_state = S_RESP;
                if (!exec_err) begin
                    case (op_q)
                        OP_PUSH: begin
                            push_c  = 1'b1;
                            wdata_c = data_q;
                        end
                        OP_POP: begin
                            pop_c = 1'b1;
                        end
                        OP_REPLACE: begin
                            push_c  = 1'b1;
                            pop_c   = 1'b1;
                            wdata_c = data_q;
                        end
                        OP_MOVE: begin
                            pop_c      = 1'b1;
                            next_state = S_MPUSH;
                        end
                        default: begin
                            push_c = 1'b0;
                        end
                    endcase
                end
            end
            S_MPUSH: begin
                // The moved word was parked in the response register during EXEC.
                push_c     = 1'b1;
                wdata_c    = rsp_data_q;
                next_state = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            op_q        <= OP_NOP;
            deque_q     <= 1'b0;
            end_q       <= 1'b0;
            dst_deque_q <= 1'b0;
            dst_end_q   <= 1'b0;
            data_q      <= '0;
            sel_q       <= 1'b0;
            dqend_q     <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            state <= next_state;
            if (state == S_IDLE && cmd_valid) begin
                op_q        <= cmd_op;
                deque_q     <= cmd_deque;
                end_q       <= cmd_end;
                dst_deque_q <= cmd_dst_deque;
                dst_end_q   <= cmd_dst_end;
                data_q      <= cmd_data;
                rsp_data_q  <= '0;
                rsp_err_q   <= cmd_illegal;
                // Select lines only move for commands that touch a deque.
                if (!cmd_direct) begin
                    sel_q   <= cmd_deque;
                    dqend_q <= cmd_end;
                end
            end
            if (state == S_EXEC) begin
                if (exec_err) begin
                    rsp_data_q <= '0;
                    rsp_err_q  <= 1'b1;
                end else begin
                    rsp_data_q <= (op_q == OP_PUSH) ? '0 : dq_rdata;
                    rsp_err_q  <= 1'b0;
                    if (op_q == OP_MOVE) begin
                        sel_q   <= dst_deque_q;
                        dqend_q <= dst_end_q;
                    end
                end
            end
            if (state == S_RESP && rsp_ready && rsp_err_q && err_count_q != 8'hFF) begin
                err_count_q <= err_count_q + 8'd1;
            end
        end
    end

    assign cmd_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign err_count = err_count_q;
    assign dq_sel    = sel_q;
    assign dq_end    = dqend_q;
    // Strobes are forced low while reset is asserted, even before the state register clears.
    assign dq_push   = push_c && rst_n;
    assign dq_pop    = pop_c && rst_n;
    assign dq_wdata  = rst_n ? wdata_c : '0;

    logic unused_end;
    assign unused_end = end_q;

endmodule

// File: tb/tb_deque_sequencer.sv
// tb/tb_deque_sequencer.sv - directed self-checking bench with two behavioural 16-deep deques
module tb_deque_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'b000;
    logic       cmd_deque = 1'b0;
    logic       cmd_end = 1'b0;
    logic       cmd_dst_deque = 1'b0;
    logic       cmd_dst_end = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic [7:0] err_count;
    logic       dq_sel, dq_end, dq_push, dq_pop;
    logic [7:0] dq_wdata;
    logic [7:0] dq_rdata;
    logic       empty0, full0, empty1, full1;

    int checks = 0;
    int errors = 0;

    deque_sequencer #(.DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_deque(cmd_deque), .cmd_end(cmd_end),
        .cmd_dst_deque(cmd_dst_deque), .cmd_dst_end(cmd_dst_end), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .err_count(err_count),
        .dq_sel(dq_sel), .dq_end(dq_end), .dq_push(dq_push), .dq_pop(dq_pop),
        .dq_wdata(dq_wdata), .dq_rdata(dq_rdata),
        .empty0(empty0), .full0(full0), .empty1(empty1), .full1(full1)
    );

    always #5 clk = ~clk;

    // Two deques sharing the strobe bus; select is registered so read data lags select by a cycle.
    logic [7:0] mem [2][16];
    int         cnt [2];
    logic       sel_r = 1'b0, end_r = 1'b0;

    initial begin
        cnt[0] = 0;
        cnt[1] = 0;
        for (int i = 0; i < 16; i++) begin
            mem[0][i] = 8'h00;
            mem[1][i] = 8'h00;
        end
    end

    always @(posedge clk) begin
        logic [7:0] t [16];
        int c;
        sel_r <= dq_sel;
        end_r <= dq_end;
        for (int a = 0; a < 2; a++) begin
            for (int i = 0; i < 16; i++) t[i] = mem[a][i];
            c = cnt[a];
            if (rst_n && (dq_sel == a[0])) begin
                if (dq_pop && c > 0) begin
                    if (!dq_end) for (int i = 0; i < 15; i++) t[i] = t[i+1];
                    c = c - 1;
                end
                if (dq_push && c < 16) begin
                    if (dq_end) begin
                        t[c] = dq_wdata;
                    end else begin
                        for (int i = 15; i > 0; i--) t[i] = t[i-1];
                        t[0] = dq_wdata;
                    end
                    c = c + 1;
                end
            end
            for (int i = 0; i < 16; i++) mem[a][i] <= t[i];
            cnt[a] <= c;
        end
    end

    always_comb begin
        dq_rdata = 8'h00;
        if (cnt[sel_r] > 0) dq_rdata = end_r ? mem[sel_r][cnt[sel_r]-1] : mem[sel_r][0];
    end

    assign empty0 = (cnt[0] == 0);
    assign full0  = (cnt[0] == 16);
    assign empty1 = (cnt[1] == 0);
    assign full1  = (cnt[1] == 16);

    int         push_cnt = 0, pop_cnt = 0;
    logic       last_push_sel = 1'b0, last_pop_sel = 1'b0;
    logic [7:0] last_push_data = 8'h00;

    always @(posedge clk) begin
        if (rst_n && dq_push) begin
            push_cnt       <= push_cnt + 1;
            last_push_sel  <= dq_sel;
            last_push_data <= dq_wdata;
        end
        if (rst_n && dq_pop) begin
            pop_cnt      <= pop_cnt + 1;
            last_pop_sel <= dq_sel;
        end
    end

    localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, PEEK = 3'd3, REPL = 3'd4, MOVE = 3'd5;

    task automatic do_cmd(input logic [2:0] op, input logic d, input logic e, input logic dd,
                          input logic de, input logic [7:0] data,
                          output logic [7:0] rd, output logic re, output int lat);
        int n;
        rd  = 8'h00;
        re  = 1'b0;
        lat = 0;
        n   = 0;
        @(negedge clk);
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL cmd_ready_timeout: cmd_ready=%b required 1", cmd_ready);
            return;
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_deque = d; cmd_end = e;
        cmd_dst_deque = dd; cmd_dst_end = de; cmd_data = data;
        @(posedge clk);
        #1;
        // Garbage on the command bus after accept must not disturb the operation.
        cmd_valid = 1'b0; cmd_op = 3'b111; cmd_deque = ~d; cmd_end = ~e;
        cmd_dst_deque = ~dd; cmd_dst_end = ~de; cmd_data = 8'hEE;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 20);
        if (!rsp_valid) begin
            checks++;
            errors++;
            $display("FAIL rsp_valid_timeout: rsp_valid=%b required 1", rsp_valid);
            return;
        end
        rd = rsp_data;
        re = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    logic [7:0] rd;
    logic       re;
    int         lat;
    int         p0;

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({cmd_ready, rsp_valid, rsp_err, dq_sel, dq_end, dq_push, dq_pop} !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_flags: got %b required 1000000",
                     {cmd_ready, rsp_valid, rsp_err, dq_sel, dq_end, dq_push, dq_pop});
        end
        checks++;
        if ({rsp_data, err_count, dq_wdata} !== 24'h0) begin
            errors++;
            $display("FAIL reset_values: got %h required 000000", {rsp_data, err_count, dq_wdata});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_push_peek();
        p0 = push_cnt;
        do_cmd(PUSH, 0, 0, 0, 0, 8'h11, rd, re, lat);
        checks++;
        if ({re, rd} !== 9'h000) begin errors++; $display("FAIL push1_rsp: got %b/%h required 0/00", re, rd); end
        checks++;
        if (push_cnt - p0 !== 1) begin errors++; $display("FAIL push1_pulses: got %0d required 1", push_cnt - p0); end
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL push_latency: got %0d required 3", lat); end
        p0 = push_cnt;
        do_cmd(PUSH, 0, 1, 0, 0, 8'h22, rd, re, lat);
        checks++;
        if (push_cnt - p0 !== 1) begin errors++; $display("FAIL push2_pulses: got %0d required 1", push_cnt - p0); end
        p0 = pop_cnt;
        do_cmd(PEEK, 0, 0, 0, 0, 8'h00, rd, re, lat);
        checks++;
        if ({re, rd} !== 9'h011) begin errors++; $display("FAIL peek_front: got %b/%h required 0/11", re, rd); end
        do_cmd(PEEK, 0, 1, 0, 0, 8'h00, rd, re, lat);
        checks++;
        if ({re, rd} !== 9'h022) begin errors++; $display("FAIL peek_back: got %b/%h required 0/22", re, rd); end
        checks++;
        if (pop_cnt - p0 !== 0) begin errors++; $display("FAIL peek_no_pop: got %0d required 0", pop_cnt - p0); end
        do_cmd(POP, 0, 0, 0, 0, 8'h00, rd, re, lat);
        checks++;
        if ({re, rd} !== 9'h011) begin errors++; $display("FAIL pop_front1: got %b/%h required 0/11", re, rd); end
        do_cmd(POP, 0, 0, 0, 0, 8'h00, rd, re, lat);
        checks++;
        if ({re, rd} !== 9'h022) begin errors++; $display("FAIL pop_front2: got %b/%h required 0/22", re, rd); end
    endtask

    task automatic test_pop_empty();
        p0 = pop_cnt;
        do_cmd(POP, 1, 0, 0, 0, 8'h00, rd, re, lat);
        checks++;
        if ({re, rd} !== 9'h100) begin errors++; $display("FAIL pop_empty_rsp: got %b/%h required 1/00", re, rd); end
        checks++;
        if (pop_cnt - p0 !== 0) begin errors++; $display("FAIL pop_empty_pulses: got %0d required 0", pop_cnt - p0); end
        checks++;
        if (err_count !== 8'd1) begin errors++; $display("FAIL err_count_1: got %0d required 1", err_count); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            do_cmd(PUSH, 0, 1, 0, 0, 8'h30 + 8'(i), rd, re, lat);
        end
        p0 = push_cnt;
        do_cmd(PUSH, 0, 1, 0, 0, 8'hFF, rd, re, lat);
        checks++;
        if (re !== 1'b1) begin errors++; $display("FAIL push_full_err: got %b required 1", re); end
        checks++;
        if (push_cnt - p0 !== 0) begin errors++; $display("FAIL push_full_pulses: got %0d required 0", push_cnt - p0); end
        checks++;
        if (err_count !== 8'd2) begin errors++; $display("FAIL err_count_2: got %0d required 2", err_count); end
        for (int i = 0; i < 16; i++) begin
            do_cmd(POP, 0, 0, 0, 0, 8'h00, rd, re, lat);
            checks++;
            if ({re, rd} !== {1'b0, 8'h30 + 8'(i)}) begin
                errors++;
                $display("FAIL fill_pop_%0d: got %b/%h required 0/%h", i, re, rd, 8'h30 + 8'(i));
            end
        end
    endtask

    task automatic test_move();
        do_cmd(PUSH, 0, 0, 0, 0, 8'hA5, rd, re, lat);
        p0 = push_cnt;
        do_cmd(MOVE, 0, 0, 1, 1, 8'h00, rd, re, lat);
        checks++;
        if ({re, rd} !== 9'h0A5) begin errors++; $display("FAIL move_rsp: got %b/%h required 0/a5", re, rd); end
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL move_latency: got %0d required 4", lat); end
        checks++;
        if ({last_pop_sel, last_push_sel, last_push_data} !== 10'b01_1010_0101) begin
            errors++;
            $display("FAIL move_strobes: got pop_sel %b push_sel %b data %h required 0 1 a5",
                     last_pop_sel, last_push_sel, last_push_data);
        end
        checks++;
        if (push_cnt - p0 !== 1) begin errors++; $display("FAIL move_push_pulses: got %0d required 1", push_cnt - p0); end
        do_cmd(PEEK, 0, 0, 0, 0, 8'h00, rd, re, lat);
        checks++;
        if (re !== 1'b1) begin errors++; $display("FAIL move_src_empty: got %b required 1", re); end
        checks++;
        if (err_count !== 8'd3) begin errors++; $display("FAIL err_count_3: got %0d required 3", err_count); end
        do_cmd(PEEK, 1, 0, 0, 0, 8'h00, rd, re, lat);
        checks++;
        if ({re, rd} !== 9'h0A5) begin errors++; $display("FAIL move_dst_peek: got %b/%h required 0/a5", re, rd); end
        do_cmd(POP, 1, 0, 0, 0, 8'h00, rd, re, lat);
    endtask

    task automatic test_move_same_and_replace();
        do_cmd(PUSH, 0, 1, 0, 0, 8'h01, rd, re, lat);
        do_cmd(PUSH, 0, 1, 0, 0, 8'h02, rd, re, lat);
        do_cmd(MOVE, 0, 1, 0, 1, 8'h00, rd, re, lat);
        checks++;
        if ({re, rd} !== 9'h002) begin errors++; $display("FAIL move_same_rsp: got %b/%h required 0/02", re, rd); end
        do_cmd(REPL, 0, 1, 0, 0, 8'h7E, rd, re, lat);
        checks++;
        if ({re, rd} !== 9'h002) begin errors++; $display("FAIL replace_rsp: got %b/%h required 0/02", re, rd); end
        do_cmd(PEEK, 0, 1, 0, 0, 8'h00, rd, re, lat);
        checks++;
        if ({re, rd} !== 9'h07E) begin errors++; $display("FAIL replace_back: got %b/%h required 0/7e", re, rd); end
        do_cmd(PEEK, 0, 0, 0, 0, 8'h00, rd, re, lat);
        checks++;
        if ({re, rd} !== 9'h001) begin errors++; $display("FAIL replace_front: got %b/%h required 0/01", re, rd); end
        checks++;
        if (cnt[0] !== 2) begin errors++; $display("FAIL replace_depth: got %0d required 2", cnt[0]); end
        do_cmd(POP, 0, 0, 0, 0, 8'h00, rd, re, lat);
        do_cmd(POP, 0, 0, 0, 0, 8'h00, rd, re, lat);
    endtask

    task automatic test_nop_illegal();
        do_cmd(NOP, 1, 1, 1, 1, 8'h99, rd, re, lat);
        checks++;
        if ({re, rd} !== 9'h000 || lat !== 1) begin
            errors++;
            $display("FAIL nop_rsp: got %b/%h lat %0d required 0/00 lat 1", re, rd, lat);
        end
        do_cmd(3'b110, 0, 0, 0, 0, 8'h00, rd, re, lat);
        checks++;
        if ({re, rd} !== 9'h100) begin errors++; $display("FAIL illegal_rsp: got %b/%h required 1/00", re, rd); end
        checks++;
        if (err_count !== 8'd4) begin errors++; $display("FAIL err_count_4: got %0d required 4", err_count); end
    endtask

    task automatic test_hold_reset();
        int n, bad;
        do_cmd(PUSH, 1, 0, 0, 0, 8'h55, rd, re, lat);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = POP; cmd_deque = 1'b1; cmd_end = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 20);
        checks++;
        if ({rsp_valid, rsp_err, rsp_data} !== 10'b10_0101_0101) begin
            errors++;
            $display("FAIL hold_rsp: got %b/%b/%h required 1/0/55", rsp_valid, rsp_err, rsp_data);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== 8'h55 || rsp_err !== 1'b0 || cmd_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL hold_stable: got %0d unstable cycles required 0", bad); end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({rsp_valid, cmd_ready, dq_push, dq_pop} !== 4'b0100) begin
            errors++;
            $display("FAIL reset_mid_rsp: got %b required 0100", {rsp_valid, cmd_ready, dq_push, dq_pop});
        end
        checks++;
        if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count: got %0d required 0", err_count); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_push_peek();
        test_pop_empty();
        test_fill();
        test_move();
        test_move_same_and_replace();
        test_nop_illegal();
        test_hold_reset();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/deque_sequencer.md
# deque_sequencer

Command front-end for the dual-deque datapath. It accepts one command at a time over a valid/ready port and expands it into the cycle-exact push/pop/select strobes the two deque instances (ADDR 0 and ADDR 1) expect. It also performs the compound MOVE and REPLACE operations and returns results over a valid/ready response port. It sits between the chip I/O decode and the deques, driving their shared strobe bus and consuming their flags and read data.

## Interface
- DATA_W, 8, data width; matches deque words.

- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer idle, command accepted this edge if cmd_valid
- cmd_op  in  3  opcode: 000 NOP, 001 PUSH, 010 POP, 011 PEEK, 100 REPLACE, 101 MOVE, 11x illegal
- cmd_deque  in  1  source/target deque
- cmd_end  in  1  source/target end (0 front, 1 back)
- cmd_dst_deque  in  1  MOVE destination deque
- cmd_dst_end  in  1  MOVE destination end
- cmd_data  in  8  PUSH/REPLACE write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_data  out  8  read value (POP/PEEK/REPLACE old value/MOVE moved value), else 0
- rsp_err  out  1  command failed, no deque state changed
- err_count  out  8  saturating count of error responses
- dq_sel, dq_end  out  1 each  deque_select / end_select to both deques
- dq_push, dq_pop  out  1 each  strobes to both deques
- dq_wdata  out  8  data_in to both deques
- dq_rdata  in  8  OR of both deque data_out
- empty0, full0, empty1, full1  in  1 each  deque flags

## Operation
- FSM states: IDLE, SEL, EXEC, MPUSH, RESP. The command fields are latched on accept (IDLE & cmd_valid).
- IDLE: cmd_ready=1. Strobes are 0. dq_sel/dq_end hold their last value. Accept goes to SEL. NOP and illegal opcodes go straight to RESP; illegal sets err=1.
- SEL: dq_sel=cmd_deque, dq_end=cmd_end, no strobes. The deque registers its select, so dq_rdata is valid next cycle. Next state is EXEC.
- EXEC: dq_sel/dq_end unchanged. Source flags are chosen by cmd_deque. Error conditions:
  - PUSH with full.
  - POP/PEEK/REPLACE/MOVE with empty.
  - MOVE with destination full while dst deque differs from src deque.
- EXEC, on error: no strobes; rsp_data=0, rsp_err=1.
- EXEC, on success, dq_rdata is captured into rsp_data (PUSH captures 0) and the strobes are:
  - PUSH: dq_push=1, dq_wdata=cmd_data.
  - POP: dq_pop=1.
  - PEEK: none.
  - REPLACE: dq_push=1, dq_pop=1, dq_wdata=cmd_data.
  - MOVE: dq_pop=1.
- EXEC next state: MOVE success goes to MPUSH; everything else goes to RESP.
- MPUSH: dq_sel=cmd_dst_deque, dq_end=cmd_dst_end, dq_push=1, dq_wdata=captured value. Next state is RESP.
- RESP: rsp_valid=1; rsp_data/rsp_err held stable. On rsp_ready, go to IDLE. err_count increments (saturating at 255) on the RESP exit edge when rsp_err=1.
- dq_push/dq_pop are asserted only in EXEC/MPUSH, each for exactly one cycle per command.

## Timing
- Reset: state IDLE, cmd_ready=1 from the first cycle after reset. All of the following are 0: rsp_valid, rsp_data, rsp_err, err_count, dq_sel, dq_end, dq_push, dq_pop, dq_wdata.
- Accept at edge T0. SEL is T0→T1, EXEC is T1→T2, rsp_valid rises after T2 (MOVE: after T3). Minimum throughput is one command per 4 cycles (5 for MOVE) with rsp_ready held high.
- A response is held indefinitely until rsp_ready; cmd_ready stays 0 meanwhile.
- Command inputs are ignored except at accept.
- Reset mid-command returns to IDLE immediately. Strobes are 0 in the reset cycle, and any pending response is discarded.
- A MOVE with the same deque and same end pops then pushes the same word; the contents are unchanged and the response is success.

## Test plan
- Reset, then PUSH d0 front 0x11, PUSH d0 back 0x22, PEEK d0 front → rsp 0x11 err 0, PEEK d0 back → 0x22; dq_push pulses exactly once per PUSH.
- POP on empty d1 → rsp_err=1, rsp_data 0, no dq_pop pulse, err_count=1.
- Fill d0 with 16 PUSHes, 17th PUSH → err=1, contents intact (16 POPs return the pushed order).
- d0 holds [0xA5], MOVE d0 front → d1 back → rsp 0xA5; dq_pop in EXEC with sel 0, dq_push 0xA5 in MPUSH with sel 1; afterwards d0 empty and d1 PEEK → 0xA5.
- REPLACE d0 back 0x7E on [0x01,0x02] → rsp 0x02, back PEEK → 0x7E, depth unchanged.
- Hold rsp_ready=0 for 10 cycles → rsp stable, cmd_ready=0; assert rst_n=0 mid-response → rsp_valid=0, cmd_ready=1 next cycle.
